// File: rtl/xor_result_collector.sv
// xor_result_collector: packs XOR-stage result bits into words and
// counts mismatches against a^b with a saturating error counter.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     upstream {in_a, in_b, in_result} handshake
//   out_valid/out_ready   downstream word handshake
//   out_word[WIDTH]       collected bits, bit i = i-th beat
//   out_mismatch          some beat of the current word mismatched
//   err_count[CNT_W]      saturating mismatch total since reset
//
// Build option: XOR_COLLECT_CORRECT_EN stores a^b instead of the
// raw result; mismatch reporting is unchanged.
module xor_result_collector #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_mismatch,
  output logic [CNT_W-1:0] err_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             drain;
  logic             mism;
  logic             bit_in;

  assign mism = in_result != (in_a ^ in_b);

`ifdef XOR_COLLECT_CORRECT_EN
  assign bit_in = in_a ^ in_b;
`else
  assign bit_in = in_result;
`endif

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    drain     = 1'b0;
    unique case (state)
      COLLECT: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && idx == LAST)
          state_nx = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        drain     = out_ready;
        if (out_ready)
          state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= COLLECT;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      out_word     <= '0;
      out_mismatch <= 1'b0;
    end else if (accept) begin
      out_word[idx] <= bit_in;
      if (mism)
        out_mismatch <= 1'b1;
      // explicit wrap keeps non-power-of-two widths in range
      if (idx == LAST)
        idx <= '0;
      else
        idx <= idx + 1'b1;
    end else if (drain) begin
      out_word     <= '0;
      out_mismatch <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (accept && mism && err_count != CNT_MAX)
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_xor_result_collector.sv
// tb_xor_result_collector: directed bench for xor_result_collector
// (WIDTH=4, CNT_W=2), checks with immediate assertions.
module tb_xor_result_collector;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_a;
  logic       in_b;
  logic       in_result;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_word;
  logic       out_mismatch;
  logic [1:0] err_count;

  int checks = 0;
  int errors = 0;

  xor_result_collector #(
    .WIDTH(4),
    .CNT_W(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_result   (in_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_mismatch(out_mismatch),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic a, input logic b, input logic r);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_result = r;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  logic [3:0] bad_word;

  initial begin
`ifdef XOR_COLLECT_CORRECT_EN
    bad_word = 4'b0110;
`else
    bad_word = 4'b0010;
`endif
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 1'b1;
    in_b      = 1'b0;
    in_result = 1'b0;
    out_ready = 1'b0;

    // reset held with in_valid high
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_err", err_count, 0);
      chk("rst_word", out_word, 0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    // clean word
    beat(0, 0, 0);
    chk("clean_not_valid_early", out_valid, 0);
    beat(0, 1, 1);
    beat(1, 0, 1);
    beat(1, 1, 0);
    chk("clean_valid", out_valid, 1);
    chk("clean_word", out_word, 4'b0110);
    chk("clean_mism", out_mismatch, 0);
    chk("clean_err", err_count, 0);
    chk("clean_in_ready", in_ready, 0);

    // backpressure with in_valid asserted in HOLD
    in_valid = 1'b1;
    in_a = 1'b1;
    in_b = 1'b1;
    in_result = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_word", out_word, 4'b0110);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    drain();
    chk("drain_valid", out_valid, 0);
    chk("drain_word", out_word, 0);
    chk("drain_in_ready", in_ready, 1);

    // bad beat 3
    beat(0, 0, 0);
    beat(0, 1, 1);
    beat(1, 0, 0);
    chk("bad_err_mid", err_count, 1);
    beat(1, 1, 0);
    chk("bad_valid", out_valid, 1);
    chk("bad_word", out_word, bad_word);
    chk("bad_mism", out_mismatch, 1);
    chk("bad_err", err_count, 1);
    drain();
    chk("bad_drain_mism", out_mismatch, 0);
    chk("bad_drain_err", err_count, 1);

    // saturation over two words
    do_reset();
    chk("sat_rst_err", err_count, 0);
    @(posedge clk);
    #1;
    beat(0, 0, 1);
    chk("sat_1", err_count, 1);
    beat(0, 0, 1);
    chk("sat_2", err_count, 2);
    beat(0, 0, 1);
    chk("sat_3", err_count, 3);
    beat(0, 0, 1);
    chk("sat_4", err_count, 3);
    chk("sat_valid", out_valid, 1);
    drain();
    beat(1, 1, 1);
    chk("sat_5", err_count, 3);
    beat(0, 0, 0);
    beat(0, 0, 0);
    // last beat with out_ready already high and in_valid kept high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 1'b0;
    in_b      = 1'b0;
    in_result = 1'b0;
    @(posedge clk);
    #1;
    chk("thru_hold", out_valid, 1);
    in_a      = 1'b1;
    in_result = 1'b1;
    @(posedge clk);
    #1;
    chk("thru_no_accept", out_word, 0);
    chk("thru_ready", in_ready, 1);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("thru_accept", out_word, 4'b0001);

    // reset mid-word
    do_reset();
    chk("midrst_word", out_word, 0);
    @(posedge clk);
    #1;
    beat(1, 0, 1);
    beat(1, 0, 1);
    do_reset();
    chk("midrst_async", out_word, 0);
    @(posedge clk);
    #1;
    beat(0, 1, 1);
    beat(0, 0, 0);
    beat(0, 0, 0);
    chk("midrst_not_done", out_valid, 0);
    beat(1, 0, 1);
    chk("midrst_valid", out_valid, 1);
    chk("midrst_word_final", out_word, 4'b1001);
    chk("midrst_mism", out_mismatch, 0);

    // reset during HOLD drops the word
    do_reset();
    chk("holdrst_valid", out_valid, 0);
    chk("holdrst_word", out_word, 0);
    chk("holdrst_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_result_collector.md
# xor_result_collector

Downstream consumer of the single-bit XOR adder stage. It accepts one `{a, b, result}` triple per handshake and checks each `result` against `a ^ b`. It packs `WIDTH` consecutive result bits, LSB first, into a word and presents that word to a downstream sink with a valid/ready handshake. It also keeps a saturating count of mismatching beats. It replaces the hand-written `$display` checking in benches with a synthesizable, self-checking collector.

## Interface
Parameters:
- `WIDTH`, default 8: result bits per output word; must be ≥ 2.
- `CNT_W`, default 8: error counter width; must be ≥ 1.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream triple is valid.
- `in_ready` output 1: collector can accept a triple.
- `in_a` input 1: operand a given to the XOR stage.
- `in_b` input 1: operand b given to the XOR stage.
- `in_result` input 1: XOR stage output for that `in_a`/`in_b`.
- `out_valid` output 1: `out_word` is complete and held.
- `out_ready` input 1: sink accepts the word.
- `out_word` output WIDTH: collected result bits; bit i = i-th accepted beat.
- `out_mismatch` output 1: at least one beat of the current word mismatched.
- `err_count` output CNT_W: saturating total of mismatching beats since reset.

## Operation
- Two-state FSM: COLLECT and HOLD; reset state COLLECT.
- COLLECT:
  - `in_ready` = 1; `out_valid` = 0.
  - Accept occurs on an edge where `in_valid && in_ready`.
  - On accept, `out_word[idx]` ← the stored bit (see Configuration).
  - On accept, mismatch = `in_result != (in_a ^ in_b)`; on mismatch, `out_mismatch` ← 1 and `err_count` increments.
  - Then `idx` increments.
- COLLECT → HOLD: on the accept where `idx == WIDTH-1`; `idx` wraps to 0.
- HOLD:
  - `in_ready` = 0; `out_valid` = 1.
  - `out_word` and `out_mismatch` are held stable.
  - `in_valid` is ignored.
- HOLD → COLLECT: on an edge with `out_valid && out_ready`. That same edge clears `out_word` to 0 and `out_mismatch` to 0.
- `idx` is a `$clog2(WIDTH)`-bit counter, reset 0.
- `err_count`:
  - Saturates at 2^CNT_W−1; no wrap.
  - Cleared only by reset, never by a word handshake.
- `in_ready` and `out_valid` are decoded directly from FSM state, with no combinational dependence on `in_valid` or `out_ready`.

## Timing
- Reset values (async, immediate on `rst_n` low):
  - `out_valid` 0, `in_ready` 1, `out_word` 0, `out_mismatch` 0, `err_count` 0, `idx` 0, state COLLECT.
- Reset mid-word: any partial word is discarded. The first accept after reset release writes bit 0.
- Reset during HOLD: the held word is dropped without a handshake.
- Latency: `out_valid` rises on the edge that accepts beat WIDTH−1, so it is visible the cycle after that beat.
- Throughput:
  - Minimum WIDTH+1 cycles per word: WIDTH accept cycles plus ≥1 HOLD cycle.
  - No beat is accepted in the HOLD cycle, even when `out_ready` is already high.
- Backpressure: `out_ready` low holds HOLD indefinitely, with all outputs stable.
- Simultaneous events: the last beat's mismatch and the `err_count` increment land on the same edge as the COLLECT→HOLD transition.

## Configuration
- `XOR_COLLECT_CORRECT_EN` defined:
  - `out_word[idx]` stores the expected value `in_a ^ in_b`, so the word is always the correct XOR stream.
  - `out_mismatch` and `err_count` still report the mismatches.
- Not defined (default): `out_word[idx]` stores the raw `in_result`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `in_valid`=1 → `in_ready`=1, `out_valid`=0, `err_count`=0, `out_word`=0 throughout.
- Clean word (WIDTH=4): beats (a,b,r) = (0,0,0), (0,1,1), (1,0,1), (1,1,0), back to back → `out_valid`=1 on the cycle after beat 4, `out_word`=4'b0110, `out_mismatch`=0, `err_count`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in HOLD while `in_valid`=1 → `out_word` stays 4'b0110 and `in_ready`=0. Raise `out_ready` → `out_valid`=0 next cycle and `out_word`=0.
- Bad beat: beat 3 = (1,0,0), other beats as in the clean word:
  - Without the macro: `out_word`=4'b0010.
  - With `XOR_COLLECT_CORRECT_EN`: `out_word`=4'b0110.
  - Both cases: `out_mismatch`=1, `err_count`=1.
- Saturation (CNT_W=2): 5 mismatching beats across two words → `err_count` reads 1, 2, 3, 3, 3.
- Reset mid-word: accept 2 beats, pulse `rst_n` low, then send 4 beats (0,1,1), (0,0,0), (0,0,0), (1,0,1) → `out_word`=4'b1001, with no residue from the pre-reset beats.
